// File: rtl/aes_pkg.sv
// Shared definitions for the AES cipher-text serializer: default widths,
// words per block and the serializer FSM encoding.
package aes_pkg;

    localparam int DATA_LEN_DEF   = 128;
    localparam int OUT_W_DEF      = 32;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int WORDS          = DATA_LEN_DEF / OUT_W_DEF;

    // Serializer states: waiting for a block, or streaming words of one.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ser_state_t;

    // Word-index width; a single-word block still needs a 1-bit index.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/aes_sync_fifo.sv
// Single-clock block FIFO with show-ahead head output. Occupancy is kept in a
// separate count register so pointers can wrap freely. A push while full is
// accepted when a pop happens on the same edge.
module aes_sync_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_pop;
    logic w_push;

    assign full   = (r_count == (PTR_W+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign level  = r_count;
    assign dout   = r_mem[r_rd_ptr];

    // An empty FIFO ignores pops; a full one takes a push only alongside a pop.
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/aes_cipher_serializer.sv
// Captures 128-bit cipher blocks from the non-stallable AES pipeline, buffers
// them and streams each block MSB-first as OUT_W-bit words on a valid/ready
// port. Blocks that find no room are dropped and flagged on a sticky overflow.
//
// Output handshake: a word transfers on a rising edge where m_valid and
// m_ready are both 1. Once m_valid is 1 it stays 1, with m_data/m_last
// stable, until that transfer; m_ready while m_valid is 0 is ignored.
module aes_cipher_serializer
    import aes_pkg::*;
#(
    parameter int DATA_LEN   = DATA_LEN_DEF,
    parameter int OUT_W      = OUT_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          data_valid_in,
    input  logic [DATA_LEN-1:0]           cipher_text,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [OUT_W-1:0]              m_data,
    output logic                          m_last,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output ser_state_t                    dbg_state
);

    localparam int N_WORDS = DATA_LEN / OUT_W;
    localparam int IDX_W   = idx_width(N_WORDS);

    ser_state_t          r_state;
    ser_state_t          w_state_next;
    logic [DATA_LEN-1:0] r_shift;
    logic [IDX_W-1:0]    r_idx;
    logic                r_m_valid;
    logic                r_overflow;

    logic [DATA_LEN-1:0] w_fifo_dout;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_pop;
    logic                w_load;
    logic                w_advance;
    logic                w_finish;
    logic                w_hs;
    logic                w_at_last;

    aes_sync_fifo #(
        .WIDTH (DATA_LEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (data_valid_in),
        .din   (cipher_text),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .level (fifo_level)
    );

    assign w_hs      = r_m_valid & m_ready;
    assign w_at_last = (r_idx == IDX_W'(N_WORDS - 1));

    assign m_valid   = r_m_valid;
    assign m_data    = r_shift[DATA_LEN-1 -: OUT_W];
    assign m_last    = r_m_valid & w_at_last;
    assign overflow  = r_overflow;
    assign dbg_state = r_state;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state plus the pop/load/advance/finish strobes for the datapath.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_load       = 1'b0;
        w_advance    = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_load       = 1'b1;
                    w_state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_hs) begin
                    if (!w_at_last) begin
                        w_advance = 1'b1;
                    end else if (!w_fifo_empty) begin
                        // Back-to-back blocks: next block's word 0 with no bubble.
                        w_pop  = 1'b1;
                        w_load = 1'b1;
                    end else begin
                        w_finish     = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Shift register, word index and output valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift   <= '0;
            r_idx     <= '0;
            r_m_valid <= 1'b0;
        end else if (w_load) begin
            r_shift   <= w_fifo_dout;
            r_idx     <= '0;
            r_m_valid <= 1'b1;
        end else if (w_advance) begin
            r_shift   <= r_shift << OUT_W;
            r_idx     <= r_idx + IDX_W'(1);
        end else if (w_finish) begin
            r_idx     <= '0;
            r_m_valid <= 1'b0;
        end
    end

    // Sticky overflow: a block arrived with the FIFO full and nothing leaving.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (data_valid_in && w_fifo_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

endmodule
